// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state/direction types and a sizing helper for the elevator controller
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_e;
  typedef enum logic {UP, DOWN} dir_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/elevator_tick_timer.sv
// elevator_tick_timer: restartable up-counter pulsing done on the last cycle of each period
// ports: clk; resetN async active-low; en counts; restart zeroes the count;
//        period = cycles per pulse; done = terminal-count pulse (count restarts after it)
module elevator_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         en,
  input  logic         restart,
  input  logic [W-1:0] period,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    done  = en && cnt_q == period - W'(1);
    cnt_d = (restart || done) ? '0 : en ? cnt_q + W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN-order elevator controller with request bitmap and shared move/door timer
// ports: clk; resetN async active-low; req_valid/req_floor request strobe; door_hold keeps door open;
//        up/down/open registered state indicators; floor current floor; pending unserved-request bitmap
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS        = 8,
  parameter int TICKS_PER_FLOOR = 50,
  parameter int DOOR_TICKS      = 100,
  localparam int FLOOR_BITS     = $clog2(N_FLOORS)
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  req_valid,
  input  logic [FLOOR_BITS-1:0] req_floor,
  input  logic                  door_hold,
  output logic                  up,
  output logic                  down,
  output logic                  open,
  output logic [FLOOR_BITS-1:0] floor,
  output logic [N_FLOORS-1:0]   pending
);
  localparam int TW = $clog2(max_int(TICKS_PER_FLOOR, DOOR_TICKS) + 1);
  localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);
  state_e state_q, state_d, scan_state;
  dir_e dir_q, dir_d;
  logic [FLOOR_BITS-1:0] floor_q, floor_d, arrive;
  logic [N_FLOORS-1:0] pending_q, pending_d, req_vec, work, above, below, arrive_vec;
  logic up_q, down_q, open_q, here_req, moving, acc, go_up, go_down, hold, tick, hit, tmr_done, restart;
  logic [TW-1:0] period;
  always_comb begin
    here_req   = req_valid && req_floor == floor_q;
    moving     = state_q == MOVE_UP || state_q == MOVE_DOWN;
    // a request for the floor we are standing at opens/holds the door instead of being queued
    acc        = req_valid && 32'(req_floor) < N_FLOORS && !(here_req && !moving);
    req_vec    = acc ? ONE << req_floor : '0;
    work       = pending_q | req_vec;
    // shifting past the top bit yields zero, so the top floor has an empty "above" mask
    above      = work & ~((ONE << floor_q << 1) - ONE);
    below      = work & ((ONE << floor_q) - ONE);
    go_up      = |above && (dir_q == UP || ~|below);
    go_down    = |below && (dir_q == DOWN || ~|above);
    scan_state = go_up ? MOVE_UP : go_down ? MOVE_DOWN : IDLE;
    hold       = state_q == DOOR_OPEN && (door_hold || here_req);
    tick       = tmr_done && !hold;
    arrive     = state_q == MOVE_UP ? floor_q + FLOOR_BITS'(1) : floor_q - FLOOR_BITS'(1);
    arrive_vec = ONE << arrive;
    hit        = moving && tick && |(work & arrive_vec);
    floor_d    = moving && tick ? arrive : floor_q;
    state_d    = state_q == IDLE ? (here_req ? DOOR_OPEN : scan_state)
               : moving ? (hit ? DOOR_OPEN : state_q)
               : tick ? scan_state : state_q;
    dir_d      = state_d == MOVE_UP ? UP : state_d == MOVE_DOWN ? DOWN : dir_q;
    pending_d  = work & ~(hit ? arrive_vec : '0);
    // every phase change starts a fresh count; move-to-move continues via the timer's own wrap
    restart    = state_d != state_q || hold;
    period     = state_q == DOOR_OPEN ? TW'(DOOR_TICKS) : TW'(TICKS_PER_FLOOR);
  end
  elevator_tick_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .resetN (resetN),
    .en     (state_q != IDLE),
    .restart(restart),
    .period (period),
    .done   (tmr_done)
  );
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q   <= IDLE;
      dir_q     <= UP;
      floor_q   <= '0;
      pending_q <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      open_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      up_q      <= state_d == MOVE_UP;
      down_q    <= state_d == MOVE_DOWN;
      open_q    <= state_d == DOOR_OPEN;
    end
  assign up      = up_q;
  assign down    = down_q;
  assign open    = open_q;
  assign floor   = floor_q;
  assign pending = pending_q;
endmodule
